// File: rtl/mac_array_pipe.sv
// mac_array_pipe: pipelined unsigned multiply-accumulate unit for framed operand streams.
// S1 registers the operands and flags, S2 registers the array-multiplier product, S3
// presents the product to the accumulate FSM, and the result registers update one edge later.
// Optional feature macro: MAC_SATURATE_EN. When it is defined, an accumulation that carries out
// clamps to all ones for the rest of the frame. When it is undefined, the sum wraps modulo 2^ACC_W.
// In both builds the carry sets out_ovf.
module mac_array_pipe #(
  parameter int WIDTH = 4,
  parameter int ACC_W = 16,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  input  logic             in_first,
  input  logic             in_last,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             out_valid,
  output logic [ACC_W-1:0] result,
  output logic             out_ovf,
  output logic [CNT_W-1:0] out_cnt,
  output logic             busy
);

  localparam int PW = 2 * WIDTH;

  typedef enum logic [0:0] {IDLE = 1'b0, ACCUM = 1'b1} state_t;

  // Pipeline stage registers
  logic             v1_q, f1_q, l1_q;
  logic [WIDTH-1:0] a1_q, b1_q;
  logic             v2_q, f2_q, l2_q;
  logic [PW-1:0]    p2_q;
  logic             v3_q, f3_q, l3_q;
  logic [PW-1:0]    p3_q;

  // Accumulator and FSM state
  state_t           state_q, state_d;
  logic [ACC_W-1:0] acc_q, acc_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             ovf_q, ovf_d;

  // Output registers
  logic             out_valid_q, out_valid_d;
  logic [ACC_W-1:0] result_q, result_d;
  logic             out_ovf_q, out_ovf_d;
  logic [CNT_W-1:0] out_cnt_q, out_cnt_d;

  // Array multiplier: AND partial products summed by a chain of row adders
  logic [PW-1:0] pp   [WIDTH];
  logic [PW-1:0] row  [WIDTH];
  logic [PW-1:0] prod;

  genvar gi;
  generate
    for (gi = 0; gi < WIDTH; gi++) begin : g_rows
      assign pp[gi] = {{WIDTH{1'b0}}, (a1_q & {WIDTH{b1_q[gi]}})} << gi;
      if (gi == 0) begin : g_first
        assign row[gi] = pp[gi];
      end else begin : g_chain
        assign row[gi] = row[gi-1] + pp[gi];
      end
    end
  endgenerate

  assign prod = row[WIDTH-1];

  // Accumulate datapath and next-state signals
  logic             restart;
  logic [ACC_W-1:0] base_acc;
  logic [ACC_W:0]   p_ext;
  logic [ACC_W:0]   sum;
  logic             carry;
  logic             ovf_new;
  logic [ACC_W-1:0] acc_new;
  logic [CNT_W-1:0] cnt_new;

  assign p_ext = {{(ACC_W + 1 - PW){1'b0}}, p3_q};

  // Accumulate arithmetic: a restarting beat (IDLE or a first flag) begins from zero
  always_comb begin
    restart  = (state_q == IDLE) | f3_q;
    base_acc = restart ? {ACC_W{1'b0}} : acc_q;
    sum      = {1'b0, base_acc} + p_ext;
    carry    = sum[ACC_W];
    ovf_new  = (restart ? 1'b0 : ovf_q) | carry;
    if (restart) begin
      cnt_new = {{(CNT_W-1){1'b0}}, 1'b1};
    end else if (cnt_q == {CNT_W{1'b1}}) begin
      cnt_new = cnt_q;
    end else begin
      cnt_new = cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
    end
`ifdef MAC_SATURATE_EN
    // Once the frame has overflowed it stays clamped until it ends
    acc_new = ovf_new ? {ACC_W{1'b1}} : sum[ACC_W-1:0];
`else
    acc_new = sum[ACC_W-1:0];
`endif
  end

  // Frame FSM: accumulate valid S3 beats, emit and clear on the last beat
  always_comb begin
    state_d     = state_q;
    acc_d       = acc_q;
    cnt_d       = cnt_q;
    ovf_d       = ovf_q;
    out_valid_d = 1'b0;
    result_d    = result_q;
    out_ovf_d   = out_ovf_q;
    out_cnt_d   = out_cnt_q;
    if (v3_q) begin
      case (state_q)
        IDLE, ACCUM: begin
          if (l3_q) begin
            out_valid_d = 1'b1;
            result_d    = acc_new;
            out_ovf_d   = ovf_new;
            out_cnt_d   = cnt_new;
            acc_d       = {ACC_W{1'b0}};
            cnt_d       = {CNT_W{1'b0}};
            ovf_d       = 1'b0;
            state_d     = IDLE;
          end else begin
            acc_d   = acc_new;
            cnt_d   = cnt_new;
            ovf_d   = ovf_new;
            state_d = ACCUM;
          end
        end
        default: begin
          state_d = IDLE;
        end
      endcase
    end else begin
      state_d = state_q;
    end
  end

  // Pipeline, accumulator and output registers with synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      v1_q        <= 1'b0;
      f1_q        <= 1'b0;
      l1_q        <= 1'b0;
      a1_q        <= {WIDTH{1'b0}};
      b1_q        <= {WIDTH{1'b0}};
      v2_q        <= 1'b0;
      f2_q        <= 1'b0;
      l2_q        <= 1'b0;
      p2_q        <= {PW{1'b0}};
      v3_q        <= 1'b0;
      f3_q        <= 1'b0;
      l3_q        <= 1'b0;
      p3_q        <= {PW{1'b0}};
      state_q     <= IDLE;
      acc_q       <= {ACC_W{1'b0}};
      cnt_q       <= {CNT_W{1'b0}};
      ovf_q       <= 1'b0;
      out_valid_q <= 1'b0;
      result_q    <= {ACC_W{1'b0}};
      out_ovf_q   <= 1'b0;
      out_cnt_q   <= {CNT_W{1'b0}};
    end else begin
      v1_q        <= in_valid;
      f1_q        <= in_first;
      l1_q        <= in_last;
      a1_q        <= a;
      b1_q        <= b;
      v2_q        <= v1_q;
      f2_q        <= f1_q;
      l2_q        <= l1_q;
      p2_q        <= prod;
      v3_q        <= v2_q;
      f3_q        <= f2_q;
      l3_q        <= l2_q;
      p3_q        <= p2_q;
      state_q     <= state_d;
      acc_q       <= acc_d;
      cnt_q       <= cnt_d;
      ovf_q       <= ovf_d;
      out_valid_q <= out_valid_d;
      result_q    <= result_d;
      out_ovf_q   <= out_ovf_d;
      out_cnt_q   <= out_cnt_d;
    end
  end

  assign out_valid = out_valid_q;
  assign result    = result_q;
  assign out_ovf   = out_ovf_q;
  assign out_cnt   = out_cnt_q;
  assign busy      = v1_q | v2_q | v3_q | (state_q == ACCUM);

endmodule

// File: tb/tb_mac_array_pipe.sv
// Scoreboard bench for mac_array_pipe (WIDTH=4, ACC_W=10, CNT_W=8).
// Stimulus pushes hand-computed frame results; a monitor pops them on every out_valid.
module tb_mac_array_pipe;

  localparam int WIDTH = 4;
  localparam int ACC_W = 10;
  localparam int CNT_W = 8;

`ifdef MAC_SATURATE_EN
  localparam int EXP4  = 1023;
  localparam int EXP4B = 1023;
`else
  localparam int EXP4  = 101;
  localparam int EXP4B = 102;
`endif

  logic             clk = 1'b0;
  logic             rst;
  logic             in_valid, in_first, in_last;
  logic [WIDTH-1:0] a, b;
  logic             out_valid;
  logic [ACC_W-1:0] result;
  logic             out_ovf;
  logic [CNT_W-1:0] out_cnt;
  logic             busy;

  typedef struct packed {
    logic [ACC_W-1:0] res;
    logic             ovf;
    logic [CNT_W-1:0] cnt;
  } exp_t;

  exp_t sb_q[$];
  int   n_tests = 0;
  int   n_fail  = 0;

  mac_array_pipe #(.WIDTH(WIDTH), .ACC_W(ACC_W), .CNT_W(CNT_W)) dut (
    .clk      (clk),
    .rst      (rst),
    .in_valid (in_valid),
    .in_first (in_first),
    .in_last  (in_last),
    .a        (a),
    .b        (b),
    .out_valid(out_valid),
    .result   (result),
    .out_ovf  (out_ovf),
    .out_cnt  (out_cnt),
    .busy     (busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic push(input int r, input int o, input int c);
    exp_t e;
    e.res = r[ACC_W-1:0];
    e.ovf = o[0];
    e.cnt = c[CNT_W-1:0];
    sb_q.push_back(e);
  endtask

  task automatic beat(input int av, input int bv, input logic f, input logic l);
    in_valid = 1'b1;
    a        = av[WIDTH-1:0];
    b        = bv[WIDTH-1:0];
    in_first = f;
    in_last  = l;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    in_first = 1'b0;
    in_last  = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic drain();
    int k;
    k = 0;
    while ((busy !== 1'b0 || out_valid !== 1'b0) && k < 60) begin
      @(posedge clk);
      #1;
      k++;
    end
    check("drain_timeout", (k < 60) ? 32'd1 : 32'd0, 32'd1);
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_out_valid"}, out_valid, 32'd0);
    check({tag, "_result"},    result,    32'd0);
    check({tag, "_out_ovf"},   out_ovf,   32'd0);
    check({tag, "_out_cnt"},   out_cnt,   32'd0);
    check({tag, "_busy"},      busy,      32'd0);
  endtask

  // Monitor: every out_valid must match the oldest outstanding expectation
  always @(negedge clk) begin
    if (out_valid === 1'b1) begin
      if (sb_q.size() == 0) begin
        n_tests++;
        n_fail++;
        $display("FAIL unexpected_out_valid: got result %0d with no expected frame", result);
      end else begin
        exp_t e;
        e = sb_q.pop_front();
        check("sb_result",  result,  e.res);
        check("sb_out_ovf", out_ovf, e.ovf);
        check("sb_out_cnt", out_cnt, e.cnt);
      end
    end
  end

  // Hard stop if the stimulus process ever stalls
  initial begin
    #500000;
    $display("FAIL global_timeout: simulation did not finish, expected completion");
    $fatal(1);
  end

  initial begin
    rst      = 1'b1;
    in_valid = 1'b0;
    in_first = 1'b0;
    in_last  = 1'b0;
    a        = '0;
    b        = '0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    check_zero("reset");

    // 1. single beat, latency and pulse width
    push(225, 0, 1);
    beat(15, 15, 1'b1, 1'b1);
    repeat (2) begin
      @(posedge clk);
      #1;
      check("lat_early", out_valid, 32'd0);
    end
    @(posedge clk);
    #1;
    check("lat_emit", out_valid, 32'd1);
    @(posedge clk);
    #1;
    check("pulse_one", out_valid, 32'd0);
    drain();

    // 2. back-to-back frame, busy high throughout
    push(44, 0, 3);
    beat(3, 5, 1'b1, 1'b0);
    check("busy_b2b_0", busy, 32'd1);
    beat(7, 2, 1'b0, 1'b0);
    check("busy_b2b_1", busy, 32'd1);
    beat(15, 1, 1'b0, 1'b1);
    check("busy_b2b_2", busy, 32'd1);
    drain();
    check("idle_busy", busy, 32'd0);

    // 3. same frame with two bubbles between beats
    push(44, 0, 3);
    beat(3, 5, 1'b1, 1'b0);
    for (int i = 0; i < 2; i++) begin
      idle(1);
      check("busy_gap_a", busy, 32'd1);
    end
    beat(7, 2, 1'b0, 1'b0);
    for (int i = 0; i < 2; i++) begin
      idle(1);
      check("busy_gap_b", busy, 32'd1);
    end
    beat(15, 1, 1'b0, 1'b1);
    drain();

    // 4. overflow: 5 x 225 = 1125
    push(EXP4, 1, 5);
    for (int i = 0; i < 5; i++) beat(15, 15, (i == 0), (i == 4));
    drain();

    // 4b. overflow is sticky and the clamp holds after a further beat
    push(EXP4B, 1, 6);
    for (int i = 0; i < 5; i++) beat(15, 15, (i == 0), 1'b0);
    beat(1, 1, 1'b0, 1'b1);
    drain();

    // 5. reset in mid-frame drops the frame and clears outputs
    beat(1, 1, 1'b1, 1'b0);
    beat(2, 2, 1'b0, 1'b0);
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    check_zero("midrst");
    idle(6);
    push(22, 0, 2);
    beat(2, 3, 1'b1, 1'b0);
    beat(4, 4, 1'b0, 1'b1);
    drain();

    // 6. first flag mid-frame discards the partial sum
    push(9, 0, 1);
    beat(2, 2, 1'b1, 1'b0);
    beat(3, 3, 1'b1, 1'b1);
    drain();

    // 7. beat without first while idle starts a frame implicitly
    push(25, 0, 1);
    beat(5, 5, 1'b0, 1'b1);
    drain();

    // 8. counter saturates at 255 over a 300-beat frame
    push(300, 0, 255);
    beat(1, 1, 1'b1, 1'b0);
    for (int i = 0; i < 298; i++) beat(1, 1, 1'b0, 1'b0);
    beat(1, 1, 1'b0, 1'b1);
    drain();

    idle(2);
    check("sb_empty", sb_q.size(), 32'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
